// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch front end. Holds the program counter,
//                issues one instruction-cache read per cycle and forwards
//                instruction/PC pairs to decode. Handles decode stalls,
//                branch redirects (squashing the in-flight read through the
//                cache nop input) and halt-opcode detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF,
    parameter int          CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_in,
    input  logic             redirect_en,
    input  logic [15:0]      redirect_pc,
    output logic [15:0]      icache_rd_dest,
    output logic             icache_rd_en,
    output logic             icache_nop,
    input  logic [15:0]      icache_rd_out,
    input  logic [15:0]      icache_pc_out,
    output logic [15:0]      inst_out,
    output logic [15:0]      inst_pc_out,
    output logic             inst_valid,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_count
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_HALT = 2'd2;

    logic [15:0]      r_pc;
    logic [1:0]       r_state;
    logic             r_issued_q;
    logic             r_halted;
    logic [CNT_W-1:0] r_fetch_count;

    logic w_inst_valid;
    logic w_halt_hit;
    logic w_rd_en;
    logic w_nop;
    logic w_count_en;
    logic w_redirect;

    // Fetch control: read strobe, squash, halt detection and delivery qualifier
    always_comb begin
        w_inst_valid = r_issued_q & (r_state != c_HALT);
        w_halt_hit   = w_inst_valid & ~stall_in & (icache_rd_out[15:12] == HALT_OPCODE);
        w_rd_en      = (r_state == c_RUN) & ~stall_in & ~redirect_en & ~w_halt_hit;
        w_nop        = redirect_en | (r_state == c_IDLE);
        w_count_en   = w_inst_valid & ~stall_in & ~redirect_en;
        // The one-cycle IDLE window after reset does not accept redirects
        w_redirect   = redirect_en & (r_state != c_IDLE);
    end

    // Program counter: redirect target, otherwise advance on every issued read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (w_redirect) begin
            r_pc <= redirect_pc;
        end else if (w_rd_en) begin
            r_pc <= r_pc + 16'd1;
        end
    end

    // State machine: one IDLE cycle after reset, RUN, HALT until redirect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: r_state <= c_RUN;
                c_RUN, c_HALT: begin
                    if (redirect_en) begin
                        r_state <= c_RUN;
                    end else if (w_halt_hit) begin
                        r_state <= c_HALT;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Outstanding-read flag: set by a read, held across stalls, killed by redirect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_issued_q <= 1'b0;
        end else if (redirect_en || w_halt_hit) begin
            r_issued_q <= 1'b0;
        end else begin
            r_issued_q <= w_rd_en | (r_issued_q & stall_in);
        end
    end

    // Halted flag: set after the halt instruction is delivered, cleared by redirect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_halted <= 1'b0;
        end else if (w_redirect) begin
            r_halted <= 1'b0;
        end else if (w_halt_hit) begin
            r_halted <= 1'b1;
        end
    end

    // Delivered-instruction counter, saturating at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_count <= '0;
        end else if (w_count_en && !(&r_fetch_count)) begin
            r_fetch_count <= r_fetch_count + CNT_W'(1);
        end
    end

    assign icache_rd_dest = r_pc;
    assign icache_rd_en   = w_rd_en;
    assign icache_nop     = w_nop;
    assign inst_out       = icache_rd_out;
    assign inst_pc_out    = icache_pc_out;
    assign inst_valid     = w_inst_valid;
    assign halted         = r_halted;
    assign fetch_count    = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit. A behavioural
//                instruction cache answers reads; per-cycle control outputs
//                come from a vector table, delivered instruction/PC pairs
//                from a scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_in = 1'b0;
    logic        redirect_en = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic [15:0] icache_rd_dest;
    logic        icache_rd_en;
    logic        icache_nop;
    logic [15:0] icache_rd_out;
    logic [15:0] icache_pc_out;
    logic [15:0] inst_out;
    logic [15:0] inst_pc_out;
    logic        inst_valid;
    logic        halted;
    logic [2:0]  fetch_count;

    fetch_unit #(
        .RESET_PC   (16'h0000),
        .HALT_OPCODE(4'hF),
        .CNT_W      (3)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .stall_in      (stall_in),
        .redirect_en   (redirect_en),
        .redirect_pc   (redirect_pc),
        .icache_rd_dest(icache_rd_dest),
        .icache_rd_en  (icache_rd_en),
        .icache_nop    (icache_nop),
        .icache_rd_out (icache_rd_out),
        .icache_pc_out (icache_pc_out),
        .inst_out      (inst_out),
        .inst_pc_out   (inst_pc_out),
        .inst_valid    (inst_valid),
        .halted        (halted),
        .fetch_count   (fetch_count)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:65535];

    // Instruction cache: registered read, nop forces zero, otherwise holds
    always @(posedge clk) begin
        if (icache_nop) begin
            icache_rd_out <= 16'h0000;
        end else if (icache_rd_en) begin
            icache_rd_out <= mem[icache_rd_dest];
            icache_pc_out <= icache_rd_dest;
        end
    end

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redir;
        logic [15:0] rpc;
        logic        en;
        logic        nop;
        logic [15:0] dest;
        logic        valid;
        logic        halted;
        logic [2:0]  cnt;
        logic        push;
    } vec_t;

    typedef struct packed {
        logic [15:0] inst;
        logic [15:0] pc;
    } exp_t;

    vec_t vecs[$];
    exp_t sbq[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic void add(logic r, logic st, logic rd, logic [15:0] rpc,
                                logic en, logic nop, logic [15:0] dest,
                                logic val, logic hal, logic [2:0] cnt, logic push);
        vec_t v;
        v.rst = r; v.stall = st; v.redir = rd; v.rpc = rpc;
        v.en = en; v.nop = nop; v.dest = dest; v.valid = val;
        v.halted = hal; v.cnt = cnt; v.push = push;
        vecs.push_back(v);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        vec_t v;
        exp_t e;

        for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
        for (int a = 0; a < 6; a++) mem[a] = 16'h1000 + 16'(a);
        mem[16'h0006] = 16'hF123;
        mem[16'h0020] = 16'h4020;
        mem[16'h0040] = 16'h2040;
        mem[16'h0041] = 16'h2041;
        mem[16'h0042] = 16'h2042;
        mem[16'hFFFF] = 16'h3FFF;

        //  rst st rd rpc       en nop dest      val hal cnt push
        // Run A: streaming from reset, halt on 0xF123, redirect out of HALT,
        // counter saturation at 7
        add(1, 0, 0, 16'h0000, 0, 1, 16'h0000, 0, 0, 3'd0, 0);
        add(0, 0, 0, 16'h0000, 0, 1, 16'h0000, 0, 0, 3'd0, 0);
        add(0, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 3'd0, 1);
        add(0, 0, 0, 16'h0000, 1, 0, 16'h0001, 1, 0, 3'd0, 1);
        add(0, 0, 0, 16'h0000, 1, 0, 16'h0002, 1, 0, 3'd1, 1);
        add(0, 0, 0, 16'h0000, 1, 0, 16'h0003, 1, 0, 3'd2, 1);
        add(0, 0, 0, 16'h0000, 1, 0, 16'h0004, 1, 0, 3'd3, 1);
        add(0, 0, 0, 16'h0000, 1, 0, 16'h0005, 1, 0, 3'd4, 1);
        add(0, 0, 0, 16'h0000, 1, 0, 16'h0006, 1, 0, 3'd5, 1);
        add(0, 0, 0, 16'h0000, 0, 0, 16'h0007, 1, 0, 3'd6, 0);
        add(0, 0, 0, 16'h0000, 0, 0, 16'h0007, 0, 1, 3'd7, 0);
        add(0, 0, 0, 16'h0000, 0, 0, 16'h0007, 0, 1, 3'd7, 0);
        add(0, 0, 1, 16'h0000, 0, 1, 16'h0007, 0, 1, 3'd7, 0);
        add(0, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 3'd7, 1);
        add(0, 0, 0, 16'h0000, 1, 0, 16'h0001, 1, 0, 3'd7, 1);
        add(0, 0, 0, 16'h0000, 1, 0, 16'h0002, 1, 0, 3'd7, 0);
        // Run B: three-cycle stall on 0x1002, then redirect to 0x0040
        add(1, 0, 0, 16'h0000, 0, 1, 16'h0000, 0, 0, 3'd0, 0);
        add(0, 0, 0, 16'h0000, 0, 1, 16'h0000, 0, 0, 3'd0, 0);
        add(0, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 3'd0, 1);
        add(0, 0, 0, 16'h0000, 1, 0, 16'h0001, 1, 0, 3'd0, 1);
        add(0, 0, 0, 16'h0000, 1, 0, 16'h0002, 1, 0, 3'd1, 1);
        add(0, 1, 0, 16'h0000, 0, 0, 16'h0003, 1, 0, 3'd2, 0);
        add(0, 1, 0, 16'h0000, 0, 0, 16'h0003, 1, 0, 3'd2, 0);
        add(0, 1, 0, 16'h0000, 0, 0, 16'h0003, 1, 0, 3'd2, 0);
        add(0, 0, 0, 16'h0000, 1, 0, 16'h0003, 1, 0, 3'd2, 1);
        add(0, 0, 0, 16'h0000, 1, 0, 16'h0004, 1, 0, 3'd3, 1);
        add(0, 0, 0, 16'h0000, 1, 0, 16'h0005, 1, 0, 3'd4, 0);
        add(0, 0, 1, 16'h0040, 0, 1, 16'h0006, 1, 0, 3'd5, 0);
        add(0, 0, 0, 16'h0000, 1, 0, 16'h0040, 0, 0, 3'd5, 1);
        add(0, 0, 0, 16'h0000, 1, 0, 16'h0041, 1, 0, 3'd5, 1);
        add(0, 0, 0, 16'h0000, 1, 0, 16'h0042, 1, 0, 3'd6, 0);
        // Run C: PC wrap at 0xFFFF, redirect to 0x0020, reset mid-stall
        add(1, 0, 0, 16'h0000, 0, 1, 16'h0000, 0, 0, 3'd0, 0);
        add(0, 0, 0, 16'h0000, 0, 1, 16'h0000, 0, 0, 3'd0, 0);
        add(0, 0, 1, 16'hFFFF, 0, 1, 16'h0000, 0, 0, 3'd0, 0);
        add(0, 0, 0, 16'h0000, 1, 0, 16'hFFFF, 0, 0, 3'd0, 1);
        add(0, 0, 0, 16'h0000, 1, 0, 16'h0000, 1, 0, 3'd0, 1);
        add(0, 0, 0, 16'h0000, 1, 0, 16'h0001, 1, 0, 3'd1, 0);
        add(0, 0, 1, 16'h0020, 0, 1, 16'h0002, 1, 0, 3'd2, 0);
        add(0, 1, 0, 16'h0000, 0, 0, 16'h0020, 0, 0, 3'd2, 0);
        add(0, 1, 0, 16'h0000, 0, 0, 16'h0020, 0, 0, 3'd2, 0);
        add(1, 1, 0, 16'h0000, 0, 1, 16'h0000, 0, 0, 3'd0, 0);
        add(0, 0, 0, 16'h0000, 0, 1, 16'h0000, 0, 0, 3'd0, 0);
        add(0, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 3'd0, 1);
        add(0, 0, 0, 16'h0000, 1, 0, 16'h0001, 1, 0, 3'd0, 1);
        add(0, 0, 0, 16'h0000, 1, 0, 16'h0002, 1, 0, 3'd1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            @(posedge clk);
            #1;
            rst         = v.rst;
            stall_in    = v.stall;
            redirect_en = v.redir;
            redirect_pc = v.rpc;
            if (v.push) sbq.push_back({mem[v.dest], v.dest});
            #1;
            if (v.rst) begin
                chk($sformatf("v%0d sb_drained", i), 32'(sbq.size()), 32'd0);
                sbq.delete();
            end
            chk($sformatf("v%0d rd_en", i),   32'(icache_rd_en),   32'(v.en));
            chk($sformatf("v%0d nop", i),     32'(icache_nop),     32'(v.nop));
            chk($sformatf("v%0d rd_dest", i), 32'(icache_rd_dest), 32'(v.dest));
            chk($sformatf("v%0d valid", i),   32'(inst_valid),     32'(v.valid));
            chk($sformatf("v%0d halted", i),  32'(halted),         32'(v.halted));
            chk($sformatf("v%0d count", i),   32'(fetch_count),    32'(v.cnt));
            if (inst_valid && !stall_in && !redirect_en && !rst) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL v%0d unexpected_delivery: got inst %h pc %h expected none",
                             i, inst_out, inst_pc_out);
                end else begin
                    e = sbq.pop_front();
                    chk($sformatf("v%0d inst", i),    32'(inst_out),    32'(e.inst));
                    chk($sformatf("v%0d inst_pc", i), 32'(inst_pc_out), 32'(e.pc));
                end
            end
        end

        chk("final sb_drained", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch front end that drives the instruction cache read port and consumes its registered output. It holds the program counter, issues one read per cycle, and forwards instruction/PC pairs to decode. It also handles decode stalls, branch redirects (squashing the in-flight read via the cache nop input) and halt detection.

Parameters:
RESET_PC, 16'h0000, PC loaded on reset
HALT_OPCODE, 4'hF, value of inst[15:12] that halts fetch
CNT_W, 32, width of delivered-instruction counter

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
stall_in  input  1  decode cannot accept an instruction this cycle
redirect_en  input  1  branch/jump taken; squash and refetch
redirect_pc  input  16  new fetch address when redirect_en=1
icache_rd_dest  output  16  cache read address (=pc register)
icache_rd_en  output  1  cache read strobe
icache_nop  output  1  forces cache rd_out to 16'h0000 next edge
icache_rd_out  input  16  cache data, valid 1 cycle after rd_en
icache_pc_out  input  16  address of icache_rd_out
inst_out  output  16  instruction to decode (=icache_rd_out)
inst_pc_out  output  16  PC of inst_out (=icache_pc_out)
inst_valid  output  1  inst_out is a live instruction
halted  output  1  fetch stopped on halt opcode
fetch_count  output  CNT_W  instructions delivered, saturating

Behaviour:
- One clock, clk. rst is asynchronous and active-high and clears all state immediately on assertion.
- Reset values: pc=RESET_PC, state=IDLE, issued_q=0, halted=0, fetch_count=0. icache_rd_en=0 and icache_nop=1 while in reset and IDLE.
- States:
  - IDLE: exactly one cycle after rst deasserts, then RUN.
  - RUN: normal fetch.
  - HALT: fetch stopped.
- halt_hit = inst_valid & ~stall_in & (inst_out[15:12]==HALT_OPCODE).
- icache_rd_en = (state==RUN) & ~stall_in & ~redirect_en & ~halt_hit. This is combinational.
- icache_nop = redirect_en | (state==IDLE). It is 0 otherwise.
- On rd_en: pc <= pc+1, 16-bit wrap (16'hFFFF -> 16'h0000).
- issued_q <= redirect_en ? 0 : (icache_rd_en | (issued_q & stall_in)).
- inst_valid = issued_q & (state!=HALT). Cache read latency is 1 cycle, so an instruction fetched at edge N is valid in cycle N+1.
- Stall: rd_en=0 and pc holds. Because the cache holds rd_out when rd_en=0 and nop=0, the pending instruction stays on inst_out and inst_valid stays 1 until the stall drops. There is no extra buffering.
- Redirect, in any state except IDLE:
  - Registered effects: pc <= redirect_pc, issued_q <= 0, state <= RUN, halted <= 0.
  - The current inst_valid is still presented but must be ignored by decode. Decode owns the redirect, so fetch_count does not count that cycle.
  - Next cycle: fetch from redirect_pc, which is delivered 2 cycles after redirect_en.
- Priority: rst > redirect_en > halt_hit > stall_in.
- Halt:
  - On halt_hit the halt instruction is delivered (counted) that cycle.
  - Next edge: state <= HALT, halted <= 1, issued_q <= 0.
  - HALT is left only by rst or redirect_en.
- fetch_count increments on inst_valid & ~stall_in & ~redirect_en and saturates at all-ones.
- Stall together with redirect: redirect wins.

Test Plan:
1. Reset with the cache preloaded with 0x1000..0x1004 at addresses 0..4, no stall → rd_dest 0,1,2,... from the first RUN cycle; inst_out 0x1000 with inst_pc_out 0, valid the next cycle; fetch_count=5 after 5 delivered instructions.
2. Assert stall_in for 3 cycles while inst_out=0x1002 → rd_en=0 and pc frozen at 3; inst_out/inst_valid held 3 cycles; count increments once, after the stall releases.
3. redirect_en with redirect_pc=0x0040 while address 5 is in flight → nop=1 that cycle; inst_valid=0 next cycle; instruction at 0x0040 valid 2 cycles after redirect.
4. Cache word 0xF123 at address 6 → delivered once; halted=1 next cycle; rd_en stays 0; then redirect to 0 → halted=0 and fetch resumes at address 0.
5. pc=0xFFFF, no stall → next rd_dest=0x0000 (wrap); inst_pc_out sequence 0xFFFF, 0x0000.
6. Assert rst mid-stall with pc=0x0020 → immediately pc=RESET_PC, inst_valid=0, rd_en=0, nop=1, halted=0, fetch_count=0; IDLE for 1 cycle, then fetch resumes at RESET_PC.
